// File: rtl/mips_pkg.sv
// Shared register-file constants and the write-back request type.
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [ADDR_W-1:0] regIdx;
        logic [DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO for buffered mult/div write-backs, with per-entry register
// match vectors so the owner can detect pending writes to a given register.
module wb_fifo #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [ADDR_W-1:0]          pushReg,
    input  logic [DATA_W-1:0]          pushData,
    input  logic                       pop,
    output logic [ADDR_W-1:0]          headReg,
    output logic [DATA_W-1:0]          headData,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    input  logic [ADDR_W-1:0]          qReg0,
    input  logic [ADDR_W-1:0]          qReg1,
    input  logic [ADDR_W-1:0]          qReg2,
    output logic [DEPTH-1:0]           hit0,
    output logic [DEPTH-1:0]           hit1,
    output logic [DEPTH-1:0]           hit2
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [ADDR_W-1:0] regMem  [DEPTH];
    logic [DATA_W-1:0] dataMem [DEPTH];
    logic [PW-1:0]     wrPtr;
    logic [PW-1:0]     rdPtr;
    logic [DEPTH-1:0]  validVec;
    logic              doPush;
    logic              doPop;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign doPush   = push && !full;
    assign doPop    = pop && !empty;
    assign headReg  = regMem[rdPtr];
    assign headData = dataMem[rdPtr];

    // Storage carries no reset; validVec masks anything stale.
    always_ff @(posedge clk) begin
        if (doPush) begin
            regMem[wrPtr]  <= pushReg;
            dataMem[wrPtr] <= pushData;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // An entry is live when its distance from the read pointer is below count.
    always_comb begin
        validVec = '0;
        hit0     = '0;
        hit1     = '0;
        hit2     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            validVec[i] = ({1'b0, PW'(i) - rdPtr} < count);
            hit0[i]     = validVec[i] && (regMem[i] == qReg0);
            hit1[i]     = validVec[i] && (regMem[i] == qReg1);
            hit2[i]     = validVec[i] && (regMem[i] == qReg2);
        end
    end

endmodule

// File: rtl/regfile_writeback_unit.sv
// Write-side front end of the register file: merges main-path and buffered
// mult/div results onto the single registered write port and flags hazards.
module regfile_writeback_unit #(
    parameter int DATA_W     = mips_pkg::DATA_W,
    parameter int ADDR_W     = mips_pkg::ADDR_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          alu_wb_valid,
    input  logic [ADDR_W-1:0]             alu_wb_reg,
    input  logic [DATA_W-1:0]             alu_wb_data,
    input  logic                          md_wb_valid,
    output logic                          md_wb_ready,
    input  logic [ADDR_W-1:0]             md_wb_reg,
    input  logic [DATA_W-1:0]             md_wb_data,
    output logic                          RegWrite,
    output logic [ADDR_W-1:0]             WriteRegister,
    output logic [DATA_W-1:0]             WriteData,
    input  logic [ADDR_W-1:0]             chk_reg1,
    input  logic [ADDR_W-1:0]             chk_reg2,
    output logic                          chk_hit1,
    output logic                          chk_hit2,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          wb_conflict
);

    import mips_pkg::*;

    localparam logic [ADDR_W-1:0] ZERO_REG = ADDR_W'(REG_ZERO);

    logic                  aluGo;
    logic                  mdAccept;
    logic                  fifoPush;
    logic                  fifoPop;
    logic                  fifoFull;
    logic                  fifoEmpty;
    logic [ADDR_W-1:0]     headReg;
    logic [DATA_W-1:0]     headData;
    logic [FIFO_DEPTH-1:0] hitVec1;
    logic [FIFO_DEPTH-1:0] hitVec2;
    logic [FIFO_DEPTH-1:0] aluHitVec;

    // mult/div handshake: a transfer happens on a rising edge when
    // md_wb_valid && md_wb_ready; ready depends only on the registered count,
    // so a same-edge pop never makes room in a full buffer. $zero requests are
    // accepted but dropped.
    assign md_wb_ready = !fifoFull && !reset;
    assign mdAccept    = md_wb_valid && md_wb_ready;
    assign fifoPush    = mdAccept && (md_wb_reg != ZERO_REG);
    assign aluGo       = alu_wb_valid && (alu_wb_reg != ZERO_REG);
    assign fifoPop     = !aluGo && !fifoEmpty;

    wb_fifo #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (reset),
        .push     (fifoPush),
        .pushReg  (md_wb_reg),
        .pushData (md_wb_data),
        .pop      (fifoPop),
        .headReg  (headReg),
        .headData (headData),
        .count    (fifo_count),
        .full     (fifoFull),
        .empty    (fifoEmpty),
        .qReg0    (chk_reg1),
        .qReg1    (chk_reg2),
        .qReg2    (alu_wb_reg),
        .hit0     (hitVec1),
        .hit1     (hitVec2),
        .hit2     (aluHitVec)
    );

    // Main path always wins; index/data hold their last value when idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            RegWrite      <= 1'b0;
            WriteRegister <= '0;
            WriteData     <= '0;
            wb_conflict   <= 1'b0;
        end else begin
            wb_conflict <= aluGo && (|aluHitVec);
            if (aluGo) begin
                RegWrite      <= 1'b1;
                WriteRegister <= alu_wb_reg;
                WriteData     <= alu_wb_data;
            end else if (fifoPop) begin
                RegWrite      <= 1'b1;
                WriteRegister <= headReg;
                WriteData     <= headData;
            end else begin
                RegWrite <= 1'b0;
            end
        end
    end

    assign chk_hit1 = (chk_reg1 != ZERO_REG) &&
                      ((|hitVec1) || (RegWrite && (WriteRegister == chk_reg1)));
    assign chk_hit2 = (chk_reg2 != ZERO_REG) &&
                      ((|hitVec2) || (RegWrite && (WriteRegister == chk_reg2)));

endmodule
